eth_tx_framer: RTL and testbench

//  Ethernet TX framer that sits downstream of the ARP responder and any other L2 payload sources.
//  - Takes a header beat {dest MAC, src MAC, EtherType} and a 32-bit payload stream.
//  - Emits one contiguous 32-bit frame stream: header prepended, payload realigned across the
//    14-byte header (16-bit shift), zero-padded to the Ethernet minimum (FCS excluded).
//  - Output feeds the MAC/FCS stage.

---
 rtl/eth_tx_framer.sv | 275 +++++++++++++++++++++++++++
 tb/tb_eth_tx_framer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: prepends the 14-byte L2 header to a 32-bit payload stream,
// realigns payload by 16 bits behind the header and zero-pads short frames to
// MIN_FRAME_BYTES (FCS excluded). The output is a single register stage.
//
// Handshake rule (all three interfaces): a beat transfers on a rising clk edge
// where valid and ready are both 1. A source holds valid and its data stable
// until that edge.
//
// FSM notes: HDR0/HDR1/HDR2 name the header word held in the output register.
// Payload words are generated from HDR2 onward (the first payload word
// replaces the HDR2 word with no bubble). The state holding the tlast beat
// stays put until that beat is accepted, then returns to IDLE.
module eth_tx_framer #(
  parameter int MIN_FRAME_BYTES = 60,
  parameter int LEN_W           = 11
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [47:0] eth_hdr_mac_dest_i,
  input  logic [47:0] eth_hdr_mac_src_i,
  input  logic [15:0] eth_hdr_mac_type_i,
  input  logic        eth_hdr_vld_i,
  output logic        eth_hdr_rdy_o,
  input  logic [31:0] eth_pay_tdata_i,
  input  logic        eth_pay_tvld_i,
  input  logic        eth_pay_tlast_i,
  input  logic [3:0]  eth_pay_tkeep_i,
  output logic        eth_pay_trdy_o,
  output logic [31:0] eth_tx_tdata_o,
  output logic        eth_tx_tvld_o,
  output logic        eth_tx_tlast_o,
  output logic [3:0]  eth_tx_tkeep_o,
  input  logic        eth_tx_trdy_i,
  output logic [15:0] tx_frame_cnt_o
);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, HDR2, DATA, FLUSH, PAD} state_t;

  localparam logic [LEN_W:0] MIN_L = (LEN_W+1)'(MIN_FRAME_BYTES);
  localparam logic [LEN_W:0] FOUR  = (LEN_W+1)'(4);

  state_t            state_q, state_d;
  logic [15:0]       dest_lo_q, dest_lo_d;
  logic [47:0]       src_q, src_d;
  logic [15:0]       carry_q, carry_d;
  logic              flush_two_q, flush_two_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       tdata_q, tdata_d;
  logic [3:0]        tkeep_q, tkeep_d;
  logic              tlast_q, tlast_d;
  logic              tvld_q, tvld_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              rdy_en_q;

  logic              ld;
  logic              hdr_rdy;
  logic              pay_rdy;
  logic [3:0]        beat_keep;
  logic [LEN_W:0]    ext;
  logic [LEN_W:0]    rem;
  logic              close_en;
  logic [31:0]       close_word;
  logic [2:0]        close_k;
  logic [2:0]        close_n;

  // Byte count (1..4) to MSB-contiguous keep.
  function automatic logic [3:0] keep_of(input logic [2:0] n);
    case (n)
      3'd1:    keep_of = 4'b1000;
      3'd2:    keep_of = 4'b1100;
      3'd3:    keep_of = 4'b1110;
      default: keep_of = 4'b1111;
    endcase
  endfunction

  // Frame byte counter add that sticks at all-ones.
  function automatic logic [LEN_W-1:0] sat_add(input logic [LEN_W-1:0] c, input logic [2:0] n);
    logic [LEN_W:0] s;
    s = {1'b0, c} + (LEN_W+1)'(n);
    sat_add = s[LEN_W] ? {LEN_W{1'b1}} : s[LEN_W-1:0];
  endfunction

  assign ld             = !tvld_q || eth_tx_trdy_i;
  assign eth_hdr_rdy_o  = hdr_rdy;
  assign eth_pay_trdy_o = pay_rdy;
  assign eth_tx_tdata_o = tdata_q;
  assign eth_tx_tvld_o  = tvld_q;
  assign eth_tx_tlast_o = tlast_q;
  assign eth_tx_tkeep_o = tkeep_q;
  assign tx_frame_cnt_o = frame_cnt_q;

  // Normalise payload keep: only a contiguous keep on the last beat is honoured.
  always_comb begin
    beat_keep = 4'b1111;
    if (eth_pay_tlast_i) begin
      case (eth_pay_tkeep_i)
        4'b1000, 4'b1100, 4'b1110: beat_keep = eth_pay_tkeep_i;
        default:                   beat_keep = 4'b1111;
      endcase
    end
  end

  // Next-state, output-stage load and frame length bookkeeping.
  always_comb begin
    state_d     = state_q;
    dest_lo_d   = dest_lo_q;
    src_d       = src_q;
    carry_d     = carry_q;
    flush_two_d = flush_two_q;
    cnt_d       = cnt_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tlast_d     = tlast_q;
    tvld_d      = tvld_q;
    frame_cnt_d = frame_cnt_q;
    hdr_rdy     = (state_q == IDLE) && rdy_en_q;
    pay_rdy     = 1'b0;
    ext         = {1'b0, cnt_q};
    rem         = MIN_L - ext;
    close_en    = 1'b0;
    close_word  = 32'h0;
    close_k     = 3'd4;
    close_n     = 3'd4;

    if (tvld_q && tlast_q) begin
      // Final beat on the output: wait for it to be taken, then go idle.
      if (eth_tx_trdy_i) begin
        tvld_d      = 1'b0;
        tlast_d     = 1'b0;
        state_d     = IDLE;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (hdr_rdy && eth_hdr_vld_i) begin
            dest_lo_d = eth_hdr_mac_dest_i[15:0];
            src_d     = eth_hdr_mac_src_i;
            carry_d   = eth_hdr_mac_type_i;   // type leads the first payload word
            tdata_d   = eth_hdr_mac_dest_i[47:16];
            tkeep_d   = 4'b1111;
            tlast_d   = 1'b0;
            tvld_d    = 1'b1;
            cnt_d     = LEN_W'(4);
            state_d   = HDR0;
          end
        end
        HDR0: begin
          if (ld) begin
            tdata_d = {dest_lo_q, src_q[47:32]};
            cnt_d   = sat_add(cnt_q, 3'd4);
            state_d = HDR1;
          end
        end
        HDR1: begin
          if (ld) begin
            tdata_d = src_q[31:0];
            cnt_d   = sat_add(cnt_q, 3'd4);
            state_d = HDR2;
          end
        end
        HDR2, DATA: begin
          pay_rdy = ld;
          if (ld) begin
            if (!eth_pay_tvld_i) begin
              tvld_d = 1'b0;
            end else if (!eth_pay_tlast_i) begin
              tdata_d = {carry_q, eth_pay_tdata_i[31:16]};
              tkeep_d = 4'b1111;
              tvld_d  = 1'b1;
              carry_d = eth_pay_tdata_i[15:0];
              cnt_d   = sat_add(cnt_q, 3'd4);
              state_d = DATA;
            end else begin
              case (beat_keep)
                4'b1000: begin
                  close_en   = 1'b1;
                  close_word = {carry_q, eth_pay_tdata_i[31:24], 8'h00};
                  close_k    = 3'd3;
                end
                4'b1100: begin
                  close_en   = 1'b1;
                  close_word = {carry_q, eth_pay_tdata_i[31:16]};
                  close_k    = 3'd4;
                end
                default: begin
                  // 3 or 4 bytes: the tail spills into a FLUSH word.
                  tdata_d     = {carry_q, eth_pay_tdata_i[31:16]};
                  tkeep_d     = 4'b1111;
                  tvld_d      = 1'b1;
                  flush_two_d = (beat_keep == 4'b1111);
                  carry_d     = (beat_keep == 4'b1111) ? eth_pay_tdata_i[15:0]
                                                       : {eth_pay_tdata_i[15:8], 8'h00};
                  cnt_d       = sat_add(cnt_q, 3'd4);
                  state_d     = FLUSH;
                end
              endcase
            end
          end
        end
        FLUSH: begin
          if (ld) begin
            close_en   = 1'b1;
            close_word = {carry_q, 16'h0000};
            close_k    = flush_two_q ? 3'd2 : 3'd1;
          end
        end
        PAD: begin
          if (ld) begin
            tdata_d = 32'h0;
            tvld_d  = 1'b1;
            if (rem <= FOUR) begin
              tlast_d = 1'b1;
              tkeep_d = keep_of(rem[2:0]);
              cnt_d   = sat_add(cnt_q, rem[2:0]);
            end else begin
              tkeep_d = 4'b1111;
              cnt_d   = sat_add(cnt_q, 3'd4);
            end
          end
        end
        default: state_d = IDLE;
      endcase

      // Last payload word: either it ends the frame or padding follows.
      if (close_en) begin
        tdata_d = close_word;
        tvld_d  = 1'b1;
        if (ext + FOUR >= MIN_L) begin
          close_n = (ext + (LEN_W+1)'(close_k) >= MIN_L) ? close_k : rem[2:0];
          tlast_d = 1'b1;
          tkeep_d = keep_of(close_n);
          cnt_d   = sat_add(cnt_q, close_n);
        end else begin
          tlast_d = 1'b0;
          tkeep_d = 4'b1111;
          cnt_d   = sat_add(cnt_q, 3'd4);
          state_d = PAD;
        end
      end
    end
  end

  // State, header capture and output register stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      dest_lo_q   <= '0;
      src_q       <= '0;
      carry_q     <= '0;
      flush_two_q <= 1'b0;
      cnt_q       <= '0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tlast_q     <= 1'b0;
      tvld_q      <= 1'b0;
      frame_cnt_q <= '0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      dest_lo_q   <= dest_lo_d;
      src_q       <= src_d;
      carry_q     <= carry_d;
      flush_two_q <= flush_two_d;
      cnt_q       <= cnt_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tlast_q     <= tlast_d;
      tvld_q      <= tvld_d;
      frame_cnt_q <= frame_cnt_d;
      rdy_en_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: frames are described by header fields and
// payload length; the expected output beats come from a byte-level frame model.
module tb_eth_tx_framer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [47:0] hdr_dest = '0;
  logic [47:0] hdr_src = '0;
  logic [15:0] hdr_type = '0;
  logic        hdr_vld = 1'b0;
  logic        hdr_rdy;
  logic [31:0] pay_tdata = '0;
  logic        pay_tvld = 1'b0;
  logic        pay_tlast = 1'b0;
  logic [3:0]  pay_tkeep = '0;
  logic        pay_trdy;
  logic [31:0] tx_tdata;
  logic        tx_tvld;
  logic        tx_tlast;
  logic [3:0]  tx_tkeep;
  logic        tx_trdy = 1'b0;
  logic [15:0] frame_cnt;

  // clock / reset
  always #5 clk = ~clk;

  eth_tx_framer dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .eth_hdr_mac_dest_i (hdr_dest),
    .eth_hdr_mac_src_i  (hdr_src),
    .eth_hdr_mac_type_i (hdr_type),
    .eth_hdr_vld_i      (hdr_vld),
    .eth_hdr_rdy_o      (hdr_rdy),
    .eth_pay_tdata_i    (pay_tdata),
    .eth_pay_tvld_i     (pay_tvld),
    .eth_pay_tlast_i    (pay_tlast),
    .eth_pay_tkeep_i    (pay_tkeep),
    .eth_pay_trdy_o     (pay_trdy),
    .eth_tx_tdata_o     (tx_tdata),
    .eth_tx_tvld_o      (tx_tvld),
    .eth_tx_tlast_o     (tx_tlast),
    .eth_tx_tkeep_o     (tx_tkeep),
    .eth_tx_trdy_i      (tx_trdy),
    .tx_frame_cnt_o     (frame_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboard: beats are {tlast, tkeep, tdata}
  logic [36:0]  exp_q[$];
  logic [111:0] hdr_q[$];
  logic [36:0]  pay_q[$];
  logic [36:0]  obs_log[$];
  int exp_frames = 0;
  bit in_frame = 1'b0;
  int gcyc = 0;
  int gap_mark = -1;
  int last_gap = -1;
  int lat_due = -1;
  logic [31:0] lat_exp = '0;
  int busy_viol = 0;
  int early_viol = 0;
  int stall_viol = 0;

  always @(posedge clk) gcyc <= gcyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue one frame: header, payload beats and the expected output beats.
  task automatic build_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                             input int p, input logic [7:0] seed, input logic [3:0] last_keep);
    logic [7:0]  pb[$];
    logic [7:0]  fb[$];
    logic [31:0] w;
    logic [3:0]  k;
    int nb, l, nw, idx, r;
    hdr_q.push_back({d, s, t});
    for (int i = 0; i < p; i++) pb.push_back(seed + 8'(7 * i));
    nb = (p + 3) / 4;
    for (int j = 0; j < nb; j++) begin
      for (int b = 0; b < 4; b++) begin
        idx = 4 * j + b;
        w[31 - 8*b -: 8] = (idx < p) ? pb[idx] : 8'hEE;
      end
      k = (j == nb - 1) ? last_keep : 4'b0101;
      pay_q.push_back({(j == nb - 1), k, w});
    end
    for (int b = 0; b < 6; b++) fb.push_back(d[47 - 8*b -: 8]);
    for (int b = 0; b < 6; b++) fb.push_back(s[47 - 8*b -: 8]);
    fb.push_back(t[15:8]);
    fb.push_back(t[7:0]);
    foreach (pb[i]) fb.push_back(pb[i]);
    l = (fb.size() < 60) ? 60 : fb.size();
    while (fb.size() < l) fb.push_back(8'h00);
    nw = (l + 3) / 4;
    for (int x = 0; x < nw; x++) begin
      for (int b = 0; b < 4; b++) begin
        idx = 4 * x + b;
        w[31 - 8*b -: 8] = (idx < l) ? fb[idx] : 8'h00;
      end
      r = l - 4 * x;
      k = (r >= 4) ? 4'b1111 : (r == 3) ? 4'b1110 : (r == 2) ? 4'b1100 : 4'b1000;
      exp_q.push_back({(x == nw - 1), k, w});
    end
    exp_frames++;
  endtask

  // driver + monitor, one loop iteration per clock
  task automatic run_cycles(input int max_cyc, input bit trdy_pat, input bit pay_bubble,
                            input int hdr_delay, input bit must_finish);
    bit pat[4];
    bit prev_stall;
    logic [36:0] held;
    logic [36:0] beat;
    int cyc;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    prev_stall = 1'b0;
    held = '0;
    cyc = 0;
    while (cyc < max_cyc && !(exp_q.size() == 0 && hdr_q.size() == 0 && pay_q.size() == 0)) begin
      @(negedge clk);
      tx_trdy = trdy_pat ? pat[cyc % 4] : 1'b1;
      if (hdr_q.size() > 0 && cyc >= hdr_delay) begin
        hdr_vld = 1'b1;
        {hdr_dest, hdr_src, hdr_type} = hdr_q[0];
      end else begin
        hdr_vld = 1'b0;
      end
      if (pay_q.size() > 0 && (!pay_bubble || $urandom_range(0, 3) != 0)) begin
        pay_tvld = 1'b1;
        {pay_tlast, pay_tkeep, pay_tdata} = pay_q[0];
      end else begin
        pay_tvld = 1'b0;
        {pay_tlast, pay_tkeep, pay_tdata} = '0;
      end
      #1;
      if (prev_stall && ({tx_tvld, tx_tlast, tx_tkeep, tx_tdata} !== {1'b1, held})) stall_viol++;
      if (lat_due == gcyc) check("hdr_latency", {tx_tvld, tx_tdata}, {1'b1, lat_exp});
      if (in_frame && hdr_rdy) busy_viol++;
      if (!in_frame && pay_trdy) early_viol++;
      if (hdr_vld && hdr_rdy) begin
        lat_exp = hdr_q[0][111:80];
        lat_due = gcyc + 1;
        void'(hdr_q.pop_front());
        in_frame = 1'b1;
        if (gap_mark >= 0) last_gap = gcyc - gap_mark;
      end
      if (pay_tvld && pay_trdy) void'(pay_q.pop_front());
      if (tx_tvld && tx_trdy) begin
        beat = {tx_tlast, tx_tkeep, tx_tdata};
        obs_log.push_back(beat);
        if (exp_q.size() == 0) check("unexpected_beat", 64'(exp_q.size()), 64'd1);
        else check("beat", beat, exp_q.pop_front());
        if (tx_tlast) begin
          in_frame = 1'b0;
          gap_mark = gcyc;
        end
      end
      prev_stall = tx_tvld && !tx_trdy;
      held = {tx_tlast, tx_tkeep, tx_tdata};
      cyc++;
    end
    if (must_finish) check("timeout_left", 64'(exp_q.size() + hdr_q.size() + pay_q.size()), 64'd0);
  endtask

  task automatic settle();
    @(negedge clk);
    hdr_vld = 1'b0;
    pay_tvld = 1'b0;
    tx_trdy = 1'b0;
    #1;
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", {hdr_rdy, pay_trdy, tx_tdata, tx_tvld, tx_tlast, tx_tkeep, frame_cnt}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    check("idle_hdr_rdy", hdr_rdy, 1);

    // ARP reply, payload valid before the header
    obs_log.delete();
    build_frame(48'hFFFFFFFFFFFF, 48'h001122334455, 16'h0806, 28, 8'h10, 4'b1111);
    run_cycles(200, 1'b0, 1'b0, 4, 1'b1);
    settle();
    check("s1_beats", obs_log.size(), 15);
    check("s1_beat0", obs_log[0][31:0], 32'hFFFFFFFF);
    check("s1_beat1", obs_log[1][31:0], 32'hFFFF0011);
    check("s1_beat2", obs_log[2][31:0], 32'h22334455);
    check("s1_beat3", obs_log[3][31:0], 32'h08061017);
    for (int i = 11; i < 15; i++) check("s1_pad_zero", obs_log[i][31:0], 32'h0);
    check("s1_final_last_keep", obs_log[14][36:32], 5'b11111);
    check("s1_frame_cnt", frame_cnt, 1);
    check("s1_pay_held_off", early_viol, 0);

    // P=46, exact minimum, payload bubbles
    obs_log.delete();
    build_frame(48'h0A0B0C0D0E0F, 48'h102030405060, 16'h0800, 46, 8'h21, 4'b1100);
    run_cycles(300, 1'b0, 1'b1, 0, 1'b1);
    settle();
    check("s2_beats", obs_log.size(), 15);
    check("s2_final_last_keep", obs_log[14][36:32], 5'b11111);

    // P=47, one byte in a FLUSH word
    obs_log.delete();
    build_frame(48'h111111111111, 48'h222222222222, 16'h86DD, 47, 8'h40, 4'b1110);
    run_cycles(300, 1'b0, 1'b0, 0, 1'b1);
    settle();
    check("s3_beats", obs_log.size(), 16);
    check("s3_final_last_keep", obs_log[15][36:32], 5'b11000);
    check("s3_final_fill", obs_log[15][23:0], 24'h0);

    // P=50
    obs_log.delete();
    build_frame(48'h333333333333, 48'h444444444444, 16'h88B5, 50, 8'h05, 4'b1100);
    run_cycles(300, 1'b0, 1'b0, 0, 1'b1);
    settle();
    check("s4_beats", obs_log.size(), 16);
    check("s4_final_last_keep", obs_log[15][36:32], 5'b11111);

    // P=48 with a non-contiguous last keep (taken as 1111)
    obs_log.delete();
    build_frame(48'h555555555555, 48'h666666666666, 16'h0806, 48, 8'h30, 4'b1010);
    run_cycles(300, 1'b0, 1'b0, 0, 1'b1);
    settle();
    check("s4b_beats", obs_log.size(), 16);
    check("s4b_final", obs_log[15], {1'b1, 4'b1100, 32'h72790000});

    // P=1, single byte then pad
    obs_log.delete();
    build_frame(48'h777777777777, 48'h888888888888, 16'h0800, 1, 8'h55, 4'b1000);
    run_cycles(300, 1'b0, 1'b0, 0, 1'b1);
    settle();
    check("s4c_beats", obs_log.size(), 15);
    check("s4c_beat3", obs_log[3][31:0], 32'h08005500);

    // ARP reply again with downstream stalls
    obs_log.delete();
    stall_viol = 0;
    build_frame(48'hFFFFFFFFFFFF, 48'h001122334455, 16'h0806, 28, 8'h10, 4'b1111);
    run_cycles(400, 1'b1, 1'b0, 0, 1'b1);
    settle();
    check("s5_beats", obs_log.size(), 15);
    check("s5_stall_hold", stall_viol, 0);
    check("s5_frame_cnt", frame_cnt, 16'(exp_frames));

    // second header waits while busy; frames back-to-back
    obs_log.delete();
    busy_viol = 0;
    gap_mark = -1;
    last_gap = -1;
    build_frame(48'h00AABBCCDDEE, 48'h001122334455, 16'h0806, 28, 8'h60, 4'b1111);
    build_frame(48'h00AABBCCDDEF, 48'h001122334455, 16'h0800, 8, 8'h70, 4'b1111);
    run_cycles(400, 1'b0, 1'b0, 0, 1'b1);
    settle();
    check("s6_beats", obs_log.size(), 30);
    check("s6_hdr_busy", busy_viol, 0);
    check("s6_gap", last_gap, 1);
    check("s6_frame_cnt", frame_cnt, 16'(exp_frames));

    // reset mid-frame, then a clean frame
    build_frame(48'h0102030405FF, 48'h0605040302FF, 16'h0800, 40, 8'h11, 4'b1111);
    run_cycles(8, 1'b0, 1'b0, 0, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    hdr_vld = 1'b0;
    pay_tvld = 1'b0;
    tx_trdy = 1'b0;
    #1;
    check("midrst_outputs", {hdr_rdy, pay_trdy, tx_tdata, tx_tvld, tx_tlast, tx_tkeep, frame_cnt}, 64'd0);
    exp_q.delete();
    hdr_q.delete();
    pay_q.delete();
    in_frame = 1'b0;
    lat_due = -1;
    gap_mark = -1;
    exp_frames = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    obs_log.delete();
    build_frame(48'hDEADBEEF0001, 48'hCAFEF00D0002, 16'h0806, 20, 8'h80, 4'b1111);
    run_cycles(300, 1'b0, 1'b0, 0, 1'b1);
    settle();
    check("post_rst_beats", obs_log.size(), 15);
    check("post_rst_frame_cnt", frame_cnt, 1);
    check("pay_held_off_all", early_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
